// File: rtl/scan_chain_controller.sv
// scan_chain_controller
// Drives one scannable register chain through scan-in, capture and scan-out
// for a stream of test patterns. Patterns come in on a valid/ready stream.
// Captured responses leave on a valid/ready stream, one per pattern and in
// pattern order.
//
// Each response is read out while the next pattern is shifted in. The final
// response of a session is flushed by a drain pass that shifts zeros in.
//
// Optional build macro SCAN_COMPARE_EN adds the following:
//   - pattern_expect, an expected value that is sampled together with its pattern
//   - resp_mismatch, which flags a response that differs from its expected value
//   - fail_sticky, which is set by any mismatching response and stays set
module scan_chain_controller #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pattern_valid,
  input  logic [WIDTH-1:0] pattern_data,
  input  logic             pattern_last,
  output logic             pattern_ready,
`ifdef SCAN_COMPARE_EN
  input  logic [WIDTH-1:0] pattern_expect,
  output logic             resp_mismatch,
  output logic             fail_sticky,
`endif
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_data,
  input  logic             resp_ready,
  output logic             scan_test,
  output logic             scan_sin,
  input  logic             scan_sout,
  output logic             scan_clk_en,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    CAPTURE,
    RESP,
    DRAIN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] pat_buf;
  logic [WIDTH-1:0] resp_buf;
  logic [CNT_W-1:0] cnt;
  logic             last_f;
  logic             have_prev;
  logic             final_f;

  logic pat_hs;
  logic resp_hs;

  assign pat_hs    = pattern_valid & pattern_ready;
  assign resp_hs   = resp_valid & resp_ready;
  assign resp_data = resp_buf;

  // Session sequencer: next state, datapath registers and registered chain controls.
  // scan_sin is registered, so pat_buf always holds the bits that have not yet
  // been presented. The MSB goes straight to scan_sin when the pattern is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      pat_buf       <= '0;
      resp_buf      <= '0;
      cnt           <= '0;
      last_f        <= 1'b0;
      have_prev     <= 1'b0;
      final_f       <= 1'b0;
      pattern_ready <= 1'b0;
      resp_valid    <= 1'b0;
      scan_test     <= 1'b0;
      scan_sin      <= 1'b0;
      scan_clk_en   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state         <= LOAD;
            have_prev     <= 1'b0;
            final_f       <= 1'b0;
            pattern_ready <= 1'b1;
            busy          <= 1'b1;
          end
        end

        LOAD: begin
          if (pat_hs) begin
            state         <= SHIFT;
            pat_buf       <= {pattern_data[WIDTH-2:0], 1'b0};
            last_f        <= pattern_last;
            cnt           <= '0;
            pattern_ready <= 1'b0;
            scan_clk_en   <= 1'b1;
            scan_test     <= 1'b1;
            scan_sin      <= pattern_data[WIDTH-1];
          end
        end

        SHIFT: begin
          pat_buf  <= {pat_buf[WIDTH-2:0], 1'b0};
          resp_buf <= {resp_buf[WIDTH-2:0], scan_sout};
          cnt      <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state     <= CAPTURE;
            scan_test <= 1'b0;
            scan_sin  <= 1'b0;
          end else begin
            scan_sin <= pat_buf[WIDTH-1];
          end
        end

        CAPTURE: begin
          have_prev <= 1'b1;
          if (have_prev) begin
            state       <= RESP;
            scan_clk_en <= 1'b0;
            resp_valid  <= 1'b1;
            final_f     <= 1'b0;
          end else if (last_f) begin
            state     <= DRAIN;
            cnt       <= '0;
            scan_test <= 1'b1;
            scan_sin  <= 1'b0;
          end else begin
            state         <= LOAD;
            scan_clk_en   <= 1'b0;
            pattern_ready <= 1'b1;
          end
        end

        RESP: begin
          if (resp_hs) begin
            resp_valid <= 1'b0;
            if (final_f) begin
              state   <= IDLE;
              final_f <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else if (last_f) begin
              state       <= DRAIN;
              cnt         <= '0;
              scan_clk_en <= 1'b1;
              scan_test   <= 1'b1;
              scan_sin    <= 1'b0;
            end else begin
              state         <= LOAD;
              pattern_ready <= 1'b1;
            end
          end
        end

        DRAIN: begin
          resp_buf <= {resp_buf[WIDTH-2:0], scan_sout};
          cnt      <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state       <= RESP;
            scan_clk_en <= 1'b0;
            scan_test   <= 1'b0;
            resp_valid  <= 1'b1;
            final_f     <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SCAN_COMPARE_EN
  logic [WIDTH-1:0] exp_cur;
  logic [WIDTH-1:0] exp_prev;

  // The response on offer belongs to the previous pattern, except for the
  // final drained response, which belongs to the most recent one.
  assign resp_mismatch = resp_valid & (resp_buf != (final_f ? exp_cur : exp_prev));

  // Track expected values one pattern behind, and latch any failure until a new session starts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_cur     <= '0;
      exp_prev    <= '0;
      fail_sticky <= 1'b0;
    end else begin
      if (pat_hs) begin
        exp_prev <= exp_cur;
        exp_cur  <= pattern_expect;
      end
      if (state == IDLE && start) begin
        fail_sticky <= 1'b0;
      end else if (resp_hs && resp_mismatch) begin
        fail_sticky <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_scan_chain_controller.sv
// Testbench for scan_chain_controller (WIDTH=8) with a behavioural scan chain
// that is clocked by clk when scan_clk_en is high.
// Inputs change 1 time unit after the rising edge. Outputs are sampled on the falling edge.
module tb_scan_chain_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       pattern_valid;
  logic [7:0] pattern_data;
  logic       pattern_last;
  logic       pattern_ready;
  logic       resp_valid;
  logic [7:0] resp_data;
  logic       resp_ready;
  logic       scan_test;
  logic       scan_sin;
  logic       scan_sout;
  logic       scan_clk_en;
  logic       busy;
  logic       done;
`ifdef SCAN_COMPARE_EN
  logic [7:0] pattern_expect;
  logic       resp_mismatch;
  logic       fail_sticky;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  scan_chain_controller #(.WIDTH(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .pattern_valid (pattern_valid),
    .pattern_data  (pattern_data),
    .pattern_last  (pattern_last),
    .pattern_ready (pattern_ready),
`ifdef SCAN_COMPARE_EN
    .pattern_expect(pattern_expect),
    .resp_mismatch (resp_mismatch),
    .fail_sticky   (fail_sticky),
`endif
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .resp_ready    (resp_ready),
    .scan_test     (scan_test),
    .scan_sin      (scan_sin),
    .scan_sout     (scan_sout),
    .scan_clk_en   (scan_clk_en),
    .busy          (busy),
    .done          (done)
  );

  // The chain captures either a constant d value or the inverse of its current contents.
  logic [7:0] chain_q = 8'h00;
  logic       chain_inv = 1'b0;
  logic [7:0] chain_dconst = 8'h3C;
  logic [7:0] chain_d;
  assign chain_d   = chain_inv ? ~chain_q : chain_dconst;
  assign scan_sout = chain_q[7];

  // Gated-clock chain model.
  always @(posedge clk) begin
    if (scan_clk_en) chain_q <= scan_test ? {chain_q[6:0], scan_sin} : chain_d;
  end

  // Monitor: records enable cycles, shifted-in bits, response handshakes and done pulses.
  int         en_count   = 0;
  int         cap_pos    = 0;
  int         done_count = 0;
  logic       sin_q[$];
  logic [7:0] resp_q[$];
  logic       mis_q[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (scan_clk_en) begin
        en_count++;
        if (!scan_test && cap_pos == 0) cap_pos = en_count;
        if (scan_test) sin_q.push_back(scan_sin);
      end
      if (resp_valid && resp_ready) begin
        resp_q.push_back(resp_data);
`ifdef SCAN_COMPARE_EN
        mis_q.push_back(resp_mismatch);
`endif
      end
      if (done) done_count++;
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic clearMonitor();
    en_count   = 0;
    cap_pos    = 0;
    done_count = 0;
    sin_q.delete();
    resp_q.delete();
    mis_q.delete();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " busy"}, busy, 0);
    checkOutput({tag, " done"}, done, 0);
    checkOutput({tag, " pattern_ready"}, pattern_ready, 0);
    checkOutput({tag, " resp_valid"}, resp_valid, 0);
    checkOutput({tag, " resp_data"}, resp_data, 0);
    checkOutput({tag, " scan_test"}, scan_test, 0);
    checkOutput({tag, " scan_sin"}, scan_sin, 0);
    checkOutput({tag, " scan_clk_en"}, scan_clk_en, 0);
`ifdef SCAN_COMPARE_EN
    checkOutput({tag, " resp_mismatch"}, resp_mismatch, 0);
    checkOutput({tag, " fail_sticky"}, fail_sticky, 0);
`endif
  endtask

  // Called 1 time unit after a rising edge. It pulses start for one cycle.
  task automatic doStart();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Offers one pattern and returns 1 time unit after the accepting edge.
  task automatic applyStimulus(input logic [7:0] p, input logic l);
    bit seen;
    seen          = 1'b0;
    pattern_data  = p;
    pattern_last  = l;
    pattern_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (pattern_ready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) checkOutput("pattern accept timeout", 0, 1);
    @(posedge clk);
    #1 pattern_valid = 1'b0;
  endtask

  // Waits for the done pulse and returns 1 time unit after the next rising edge.
  task automatic waitDone(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) checkOutput({tag, " done timeout"}, 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic waitRespValid(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) checkOutput({tag, " resp_valid timeout"}, 0, 1);
  endtask

  // Single pattern 0xA5, last=1, with the chain capturing 0x3C.
  task automatic runScenario1(input string tag);
    logic [7:0] p;
    p            = 8'hA5;
    chain_inv    = 1'b0;
    chain_dconst = 8'h3C;
    resp_ready   = 1'b1;
    clearMonitor();
    doStart();
    checkOutput({tag, " busy after start"}, busy, 1);
    applyStimulus(p, 1'b1);
    waitDone(tag);
    checkOutput({tag, " sin count"}, sin_q.size(), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < sin_q.size())
        checkOutput($sformatf("%s sin[%0d]", tag, i), sin_q[i], (i < 8) ? p[7-i] : 1'b0);
    end
    checkOutput({tag, " capture position"}, cap_pos, 9);
    checkOutput({tag, " enable cycles"}, en_count, 17);
    checkOutput({tag, " resp count"}, resp_q.size(), 1);
    if (resp_q.size() > 0) checkOutput({tag, " resp0"}, resp_q[0], 8'h3C);
    checkOutput({tag, " done pulses"}, done_count, 1);
    checkOutput({tag, " busy end"}, busy, 0);
    checkOutput({tag, " done cleared"}, done, 0);
  endtask

  typedef struct {
    logic [7:0] pat;
    logic       last;
    logic [7:0] resp;
  } vec_t;

  initial begin
    vec_t       vecs[3];
    logic [7:0] q_before;
    logic [7:0] held;

    vecs[0] = '{pat: 8'h01, last: 1'b0, resp: 8'hFE};
    vecs[1] = '{pat: 8'h80, last: 1'b0, resp: 8'h7F};
    vecs[2] = '{pat: 8'hFF, last: 1'b1, resp: 8'h00};

    reset         = 1'b1;
    start         = 1'b0;
    pattern_valid = 1'b0;
    pattern_data  = 8'h00;
    pattern_last  = 1'b0;
    resp_ready    = 1'b1;
`ifdef SCAN_COMPARE_EN
    pattern_expect = 8'h00;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;

    // In IDLE, an offered pattern is not accepted and the block stays idle.
    pattern_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("idle pattern_ready", pattern_ready, 0);
    checkOutput("idle busy", busy, 0);
    @(posedge clk);
    #1 pattern_valid = 1'b0;

    $display("[TB] scenario 1: single pattern");
    runScenario1("s1");

    $display("[TB] scenario 2: three patterns, d = ~q");
    chain_inv  = 1'b1;
    resp_ready = 1'b1;
    clearMonitor();
    doStart();
    for (int i = 0; i < 3; i++) applyStimulus(vecs[i].pat, vecs[i].last);
    waitDone("s2");
    checkOutput("s2 resp count", resp_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < resp_q.size()) checkOutput($sformatf("s2 resp[%0d]", i), resp_q[i], vecs[i].resp);
    end
    checkOutput("s2 done pulses", done_count, 1);

    $display("[TB] scenario 3: response back-pressure");
    chain_inv  = 1'b1;
    resp_ready = 1'b0;
    clearMonitor();
    doStart();
    applyStimulus(8'h12, 1'b0);
    applyStimulus(8'h34, 1'b1);
    waitRespValid("s3");
    held = resp_data;
    checkOutput("s3 first resp value", held, 8'hED);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput($sformatf("s3 c%0d resp_valid", i), resp_valid, 1);
      checkOutput($sformatf("s3 c%0d resp_data", i), resp_data, 8'hED);
      checkOutput($sformatf("s3 c%0d scan_clk_en", i), scan_clk_en, 0);
      checkOutput($sformatf("s3 c%0d pattern_ready", i), pattern_ready, 0);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    waitDone("s3");
    checkOutput("s3 resp count", resp_q.size(), 2);
    if (resp_q.size() > 0) checkOutput("s3 resp0", resp_q[0], 8'hED);
    if (resp_q.size() > 1) checkOutput("s3 resp1", resp_q[1], 8'hCB);

    $display("[TB] scenario 4: pattern_valid held low in LOAD");
    chain_inv    = 1'b0;
    chain_dconst = 8'h3C;
    clearMonitor();
    doStart();
    pattern_valid = 1'b0;
    q_before = chain_q;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("s4 c%0d scan_clk_en", i), scan_clk_en, 0);
      checkOutput($sformatf("s4 c%0d pattern_ready", i), pattern_ready, 1);
      checkOutput($sformatf("s4 c%0d chain hold", i), chain_q, q_before);
    end
    @(posedge clk);
    #1;
    pattern_data  = 8'h96;
    pattern_last  = 1'b1;
    pattern_valid = 1'b1;
    @(negedge clk);
    checkOutput("s4 ready at valid", pattern_ready, 1);
    @(posedge clk);
    #1 pattern_valid = 1'b0;
    @(negedge clk);
    checkOutput("s4 shift en", scan_clk_en, 1);
    checkOutput("s4 shift test", scan_test, 1);
    checkOutput("s4 shift sin msb", scan_sin, 1);
    checkOutput("s4 ready dropped", pattern_ready, 0);
    @(posedge clk);
    #1;
    waitDone("s4");
    checkOutput("s4 resp count", resp_q.size(), 1);
    if (resp_q.size() > 0) checkOutput("s4 resp0", resp_q[0], 8'h3C);

    $display("[TB] scenario 5: reset during SHIFT");
    chain_inv = 1'b0;
    clearMonitor();
    doStart();
    applyStimulus(8'hA5, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("s5 in shift", scan_clk_en, 1);
    reset = 1'b1;
    #1;
    checkAllZero("s5 reset");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    runScenario1("s5");

`ifdef SCAN_COMPARE_EN
    $display("[TB] scenario 6: response compare");
    chain_inv      = 1'b0;
    chain_dconst   = 8'h3C;
    pattern_expect = 8'h00;
    clearMonitor();
    doStart();
    checkOutput("s6 sticky after start", fail_sticky, 0);
    applyStimulus(8'h55, 1'b1);
    waitDone("s6a");
    checkOutput("s6a resp count", mis_q.size(), 1);
    if (mis_q.size() > 0) checkOutput("s6a mismatch", mis_q[0], 1);
    checkOutput("s6a sticky", fail_sticky, 1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("s6a sticky held", fail_sticky, 1);
    pattern_expect = 8'h3C;
    clearMonitor();
    doStart();
    checkOutput("s6b sticky cleared", fail_sticky, 0);
    applyStimulus(8'h55, 1'b1);
    waitDone("s6b");
    checkOutput("s6b resp count", mis_q.size(), 1);
    if (mis_q.size() > 0) checkOutput("s6b mismatch", mis_q[0], 0);
    checkOutput("s6b sticky", fail_sticky, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
